// File: rtl/ondra_prn_pkg.sv
// Shared types and default timing constants for the Ondra printer-port
// capture block.
//   prn_state_t     : capture FSM state encoding
//   SETTLE_CYC_DEF  : cycles a strobe must stay low before it is accepted
//   BUSY_CYC_DEF    : cycles BUSY is held after a byte is stored
//   max_int()       : helper used to size the shared settle/hold counter
package ondra_prn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PUSH,
    HOLD,
    RELEASE
  } prn_state_t;

  localparam int SETTLE_CYC_DEF = 8;
  localparam int BUSY_CYC_DEF   = 40;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ondra_printer_capture_if.sv
// Bundle of the printer-port and stream signals around the capture block.
//   printer side : prn_data, prn_stb_n (from core), busy (to core)
//   stream side  : out_data, out_valid (to writer), out_ready (from writer)
//   status       : fifo_level, dbg_state (FSM state, observation only)
// Stream handshake: a byte transfers on every rising clk_sys edge where
// out_valid and out_ready are both 1; out_valid/out_data do not depend on
// out_ready and stay stable until the transfer happens.
// Modports: master = capture block, slave = core/writer environment.
interface ondra_printer_capture_if
  import ondra_prn_pkg::*;
#(
  parameter int FIFO_AW = 4
);
  logic [7:0]       prn_data;
  logic             prn_stb_n;
  logic             busy;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [FIFO_AW:0] fifo_level;
  prn_state_t       dbg_state;

  modport master (
    input  prn_data, prn_stb_n, out_ready,
    output busy, out_data, out_valid, fifo_level, dbg_state
  );

  modport slave (
    output prn_data, prn_stb_n, out_ready,
    input  busy, out_data, out_valid, fifo_level, dbg_state
  );
endinterface

// File: rtl/ondra_prn_fifo.sv
// First-word-fall-through byte FIFO, depth 2**FIFO_AW.
//   wr_en/wr_data : push request; accepted when not full, or when a pop
//                   happens in the same cycle (the pop frees the slot)
//   rd_en         : pop request; accepted when not empty
//   rd_data       : head byte (0 while empty)
//   empty/full    : derived from (FIFO_AW+1)-bit wrapping pointers
//   level         : wr_ptr - rd_ptr
module ondra_prn_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [FIFO_AW:0] level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PTR_W = FIFO_AW + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
               (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    level    = wr_ptr_q - rd_ptr_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: rd_data is forced to 0 while empty.
  always_ff @(posedge clk_sys) begin
    if (do_wr) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ondra_printer_capture.sv
// Printer-port capture for the Ondra core: synchronises the core's strobe
// and data, deglitches the strobe, stores each accepted byte in a FWFT FIFO
// and returns a BUSY handshake so the ROM printer routine paces itself.
//   clk_sys, reset_n : sole clock, asynchronous active-low reset
//   bus (master)     : prn_data/prn_stb_n in, busy out, out_* byte stream,
//                      fifo_level and dbg_state status
module ondra_printer_capture
  import ondra_prn_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int BUSY_CYC   = BUSY_CYC_DEF
) (
  input logic                     clk_sys,
  input logic                     reset_n,
  ondra_printer_capture_if.master bus
);
  localparam int CNT_W = $clog2(max_int(SETTLE_CYC, BUSY_CYC)) + 1;

  logic             stb_meta_q, stb_meta_d, stb_sync_q, stb_sync_d;
  logic [7:0]       data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic [1:0]       sync_fill_q, sync_fill_d;
  logic             armed_q, armed_d;
  prn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             wr_en, pop;
  logic             fifo_empty, fifo_full;
  logic [7:0]       fifo_rd_data;
  logic [FIFO_AW:0] fifo_level;

  always_comb begin
    stb_meta_d  = bus.prn_stb_n;
    stb_sync_d  = stb_meta_q;
    data_meta_d = bus.prn_data;
    data_sync_d = data_meta_q;
    // sync_fill marks when the synchroniser holds real samples instead of
    // its reset preset; only then can a high strobe arm the FSM. This keeps
    // a strobe already low at reset exit from being taken as a new edge.
    sync_fill_d = {sync_fill_q[0], 1'b1};
    armed_d     = armed_q | (sync_fill_q[1] & stb_sync_q);
    pop         = ~fifo_empty & bus.out_ready;

    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      // IDLE is only entered with the strobe high, so low here is a fall.
      IDLE: begin
        if (armed_q && !stb_sync_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (stb_sync_q)                              state_d = IDLE;
        else if (cnt_q == CNT_W'(SETTLE_CYC - 1))    state_d = PUSH;
        else                                         cnt_d   = cnt_q + CNT_W'(1);
      end
      // A pop in the same cycle frees a slot even when the FIFO is full.
      PUSH: begin
        if (!fifo_full || pop) begin
          wr_en   = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(BUSY_CYC - 1)) state_d = RELEASE;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      RELEASE: begin
        if (stb_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_q != IDLE) | fifo_full;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stb_meta_q  <= 1'b1;
      stb_sync_q  <= 1'b1;
      data_meta_q <= '0;
      data_sync_q <= '0;
      sync_fill_q <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      stb_meta_q  <= stb_meta_d;
      stb_sync_q  <= stb_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      sync_fill_q <= sync_fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  ondra_prn_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (data_sync_q),
    .rd_en   (bus.out_ready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign bus.busy       = busy_q;
  assign bus.out_data   = fifo_rd_data;
  assign bus.out_valid  = ~fifo_empty;
  assign bus.fifo_level = fifo_level;
  assign bus.dbg_state  = state_q;

endmodule
